voice_scheduler: RTL and testbench

VOICE_SCHEDULER -- requirements
Module: voice_scheduler

---
 rtl/voice_scheduler.sv | 149 ++++++++++++++
 tb/tb_voice_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Fetches note words, places each on a fixed or first-free voice, and counts every voice down on a shared tick.
// Latency: request one cycle after IDLE, placement one cycle after capture. A word stalls in WAIT until its voice frees.
module voice_scheduler #(
  parameter int TICK_DIV = 2750,
  parameter int ADDR_W   = 30
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              play,
  output logic              note_req,
  output logic [ADDR_W-1:0] note_addr,
  input  logic              note_valid,
  input  logic [31:0]       note_data,
  output logic [11:0]       freq1,
  output logic [11:0]       freq2,
  output logic [11:0]       freq3,
  output logic [11:0]       freq4,
  output logic [3:0]        voice_busy,
  output logic              song_end
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_PLACE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  logic [1:0]  state;
  logic [11:0] pre_cnt;
  logic        tick;

  logic [11:0] w_hp;
  logic [7:0]  w_len;
  logic [1:0]  w_voice;
  logic        w_any;
  logic        w_eos;

  logic [11:0] freq_q [4];
  logic [7:0]  len_q  [4];

  logic [1:0]  tgt;
  logic        tgt_free;
  logic        evaluating;
  logic        advance;
  logic        load;
  logic        unused_data;

  assign unused_data = ^note_data[30:23];

  assign tick = (pre_cnt == 12'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) pre_cnt <= '0;
    else if (tick) pre_cnt <= '0;
    else pre_cnt <= pre_cnt + 12'd1;
  end

  // Uses registered busy, so a voice freed at this edge is only visible next cycle.
  always_comb begin
    tgt      = w_voice;
    tgt_free = !voice_busy[w_voice];
    if (w_any) begin
      tgt      = 2'd0;
      tgt_free = 1'b0;
      for (int i = 3; i >= 0; i--) begin
        if (!voice_busy[i]) begin
          tgt      = 2'(i);
          tgt_free = 1'b1;
        end
      end
    end
  end

  assign evaluating = (state == S_PLACE) || (state == S_WAIT);
  assign advance    = evaluating && (w_eos || (w_len == 8'd0) || tgt_free);
  assign load       = evaluating && !w_eos && (w_len != 8'd0) && tgt_free;
  assign note_req   = (state == S_FETCH);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      note_addr <= '0;
      song_end  <= 1'b0;
      w_hp      <= '0;
      w_len     <= '0;
      w_voice   <= '0;
      w_any     <= 1'b0;
      w_eos     <= 1'b0;
    end else begin
      song_end <= 1'b0;
      case (state)
        S_IDLE: if (play) state <= S_FETCH;
        S_FETCH: begin
          if (note_valid) begin
            w_hp    <= note_data[11:0];
            w_len   <= note_data[19:12];
            w_voice <= note_data[21:20];
            w_any   <= note_data[22];
            w_eos   <= note_data[31];
            state   <= S_PLACE;
          end
        end
        default: begin
          if (advance) begin
            if (w_eos) begin
              note_addr <= '0;
              song_end  <= 1'b1;
            end else begin
              note_addr <= note_addr + ADDR_W'(1);
            end
            state <= play ? S_FETCH : S_IDLE;
          end else begin
            state <= S_WAIT;
          end
        end
      endcase
    end
  end

  // Loads only hit free voices, so a load never collides with a decrement.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      voice_busy <= '0;
      for (int i = 0; i < 4; i++) begin
        freq_q[i] <= '0;
        len_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (load && (tgt == 2'(i))) begin
          freq_q[i]     <= w_hp;
          len_q[i]      <= w_len;
          voice_busy[i] <= 1'b1;
        end else if (tick && voice_busy[i]) begin
          len_q[i] <= len_q[i] - 8'd1;
          if (len_q[i] == 8'd1) begin
            freq_q[i]     <= '0;
            voice_busy[i] <= 1'b0;
          end
        end
      end
    end
  end

  assign freq1 = freq_q[0];
  assign freq2 = freq_q[1];
  assign freq3 = freq_q[2];
  assign freq4 = freq_q[3];

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler with TICK_DIV=4 and a 16-word note memory.
module tb_voice_scheduler;
  localparam int TD = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          play = 1'b0;
  logic          note_valid = 1'b0;
  logic [31:0]   note_data = '0;
  logic          note_req;
  logic [AW-1:0] note_addr;
  logic [11:0]   freq1, freq2, freq3, freq4;
  logic [3:0]    voice_busy;
  logic          song_end;

  logic [31:0] mem [16];
  int checks = 0;
  int failures = 0;

  voice_scheduler #(.TICK_DIV(TD), .ADDR_W(AW)) dut (
    .clk(clk), .reset_n(reset_n), .play(play),
    .note_req(note_req), .note_addr(note_addr),
    .note_valid(note_valid), .note_data(note_data),
    .freq1(freq1), .freq2(freq2), .freq3(freq3), .freq4(freq4),
    .voice_busy(voice_busy), .song_end(song_end)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic eos, input logic any, input logic [1:0] v,
                                     input logic [7:0] len, input logic [11:0] hp);
    return {eos, 8'd0, any, v, len, hp};
  endfunction

  // Memory answers two negedges after it sees the request.
  initial begin
    int wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      if (!reset_n || note_valid) begin
        note_valid = 1'b0;
        wcnt = 0;
      end else if (note_req) begin
        wcnt++;
        if (wcnt >= 2) begin
          note_valid = 1'b1;
          note_data = mem[note_addr];
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'd0;
  endtask

  task automatic do_reset();
    play = 1'b0;
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_mem();
    reset_n = 1'b0;
    #3;
    checks++; if ({note_req, note_addr, song_end} !== '0) begin failures++; $display("FAIL reset_ctl: got %b_%h_%b want 0", note_req, note_addr, song_end); end
    checks++; if ({freq1, freq2, freq3, freq4, voice_busy} !== '0) begin failures++; $display("FAIL reset_voices: got %h %h %h %h %b want 0", freq1, freq2, freq3, freq4, voice_busy); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (note_req !== 1'b0) begin failures++; $display("FAIL idle_no_play: note_req=%b want 0", note_req); end
  endtask

  task automatic test_single();
    int n;
    clear_mem();
    mem[0] = mk(1'b0, 1'b0, 2'd1, 8'd3, 12'h123);
    do_reset();
    play = 1'b1;
    n = 0;
    while (freq2 == 12'd0 && n < 30) begin @(negedge clk); n++; end
    checks++; if (freq2 !== 12'h123) begin failures++; $display("FAIL single_freq2: got %h want 123", freq2); end
    checks++; if (voice_busy !== 4'b0010) begin failures++; $display("FAIL single_busy: got %b want 0010", voice_busy); end
    n = 0;
    while (freq2 != 12'd0 && n < 40) begin @(negedge clk); n++; end
    checks++; if (n < 9 || n > 12) begin failures++; $display("FAIL single_duration: got %0d cycles want 9..12", n); end
    checks++; if (voice_busy !== 4'b0000) begin failures++; $display("FAIL single_clear: busy=%b want 0000", voice_busy); end
    play = 1'b0;
  endtask

  task automatic test_wait();
    int n;
    clear_mem();
    mem[0] = mk(1'b0, 1'b0, 2'd0, 8'd2, 12'h0AA);
    mem[1] = mk(1'b0, 1'b0, 2'd0, 8'd2, 12'h0BB);
    do_reset();
    play = 1'b1;
    n = 0;
    while (freq1 == 12'd0 && n < 30) begin @(negedge clk); n++; end
    checks++; if (freq1 !== 12'h0AA) begin failures++; $display("FAIL wait_first: freq1=%h want 0aa", freq1); end
    repeat (4) @(negedge clk);
    checks++; if ({note_req, voice_busy} !== 5'b0_0001) begin failures++; $display("FAIL wait_holding: req=%b busy=%b want 0 0001", note_req, voice_busy); end
    n = 0;
    while (freq1 == 12'h0AA && n < 20) begin @(negedge clk); n++; end
    checks++; if ({freq1, voice_busy} !== 16'h0000) begin failures++; $display("FAIL wait_clear: freq1=%h busy=%b want 000 0000", freq1, voice_busy); end
    @(negedge clk);
    checks++; if ({freq1, voice_busy} !== {12'h0BB, 4'b0001}) begin failures++; $display("FAIL wait_reload: freq1=%h busy=%b want 0bb 0001", freq1, voice_busy); end
    play = 1'b0;
  endtask

  task automatic test_any();
    int n;
    clear_mem();
    for (int i = 0; i < 4; i++) mem[i] = mk(1'b0, 1'b1, 2'd3, 8'd5, 12'(12'h101 + i));
    mem[4] = mk(1'b0, 1'b1, 2'd2, 8'd2, 12'h105);
    do_reset();
    play = 1'b1;
    n = 0;
    while (voice_busy != 4'b1111 && n < 60) begin @(negedge clk); n++; end
    checks++; if ({freq1, freq2, freq3, freq4} !== {12'h101, 12'h102, 12'h103, 12'h104}) begin failures++; $display("FAIL any_fill: got %h %h %h %h want 101 102 103 104", freq1, freq2, freq3, freq4); end
    n = 0;
    while (voice_busy[0] && n < 40) begin @(negedge clk); n++; end
    checks++; if (freq1 !== 12'h000) begin failures++; $display("FAIL any_v1_clear: freq1=%h want 000", freq1); end
    @(negedge clk);
    checks++; if ({freq1, voice_busy[0]} !== {12'h105, 1'b1}) begin failures++; $display("FAIL any_fifth: freq1=%h busy0=%b want 105 1", freq1, voice_busy[0]); end
    play = 1'b0;
  endtask

  task automatic test_song_end();
    int n;
    logic [AW-1:0] prev;
    clear_mem();
    mem[5] = mk(1'b1, 1'b0, 2'd0, 8'd3, 12'h077);
    do_reset();
    play = 1'b1;
    n = 0;
    prev = '0;
    while (!song_end && n < 60) begin prev = note_addr; @(negedge clk); n++; end
    checks++; if (song_end !== 1'b1 || prev !== 4'd5) begin failures++; $display("FAIL eos_pulse: song_end=%b from addr %0d want 1 from 5", song_end, prev); end
    checks++; if ({note_addr, note_req} !== {4'd0, 1'b1}) begin failures++; $display("FAIL eos_addr: addr=%0d req=%b want 0 1", note_addr, note_req); end
    checks++; if ({freq1, voice_busy} !== 16'h0000) begin failures++; $display("FAIL eos_unplayed: freq1=%h busy=%b want 0", freq1, voice_busy); end
    @(negedge clk);
    checks++; if (song_end !== 1'b0) begin failures++; $display("FAIL eos_single: song_end=%b want 0", song_end); end
    play = 1'b0;
  endtask

  task automatic test_skip_rest();
    int n;
    clear_mem();
    mem[0] = mk(1'b0, 1'b0, 2'd0, 8'd0, 12'h055);
    mem[1] = mk(1'b0, 1'b0, 2'd2, 8'd2, 12'h000);
    do_reset();
    play = 1'b1;
    n = 0;
    while (note_addr != 4'd1 && n < 20) begin @(negedge clk); n++; end
    checks++; if ({note_addr, voice_busy, freq1} !== {4'd1, 4'b0000, 12'h000}) begin failures++; $display("FAIL skip_len0: addr=%0d busy=%b freq1=%h want 1 0000 000", note_addr, voice_busy, freq1); end
    n = 0;
    while (voice_busy == 4'b0000 && n < 20) begin @(negedge clk); n++; end
    checks++; if ({voice_busy, freq3} !== {4'b0100, 12'h000}) begin failures++; $display("FAIL rest_load: busy=%b freq3=%h want 0100 000", voice_busy, freq3); end
    n = 0;
    while (voice_busy != 4'b0000 && n < 20) begin @(negedge clk); n++; end
    checks++; if (n < 5 || n > 8) begin failures++; $display("FAIL rest_duration: got %0d cycles want 5..8", n); end
    play = 1'b0;
  endtask

  task automatic test_wrap();
    int n;
    logic seen;
    clear_mem();
    do_reset();
    play = 1'b1;
    n = 0;
    while (note_addr != 4'd15 && n < 80) begin @(negedge clk); n++; end
    checks++; if (note_addr !== 4'd15) begin failures++; $display("FAIL wrap_reach: addr=%0d want 15", note_addr); end
    n = 0;
    seen = 1'b0;
    while (note_addr != 4'd0 && n < 10) begin @(negedge clk); seen = seen | song_end; n++; end
    checks++; if ({note_addr, seen} !== {4'd0, 1'b0}) begin failures++; $display("FAIL wrap_silent: addr=%0d song_end_seen=%b want 0 0", note_addr, seen); end
    play = 1'b0;
  endtask

  task automatic test_reset_mid();
    int n;
    clear_mem();
    mem[0] = mk(1'b0, 1'b0, 2'd0, 8'd10, 12'h3AA);
    mem[1] = mk(1'b0, 1'b0, 2'd1, 8'd10, 12'h2BB);
    do_reset();
    play = 1'b1;
    n = 0;
    while (voice_busy != 4'b0001 && n < 30) begin @(negedge clk); n++; end
    checks++; if ({voice_busy, note_req, note_addr} !== {4'b0001, 1'b1, 4'd1}) begin failures++; $display("FAIL mid_fetch: busy=%b req=%b addr=%0d want 0001 1 1", voice_busy, note_req, note_addr); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if ({note_req, note_addr, song_end, voice_busy} !== '0) begin failures++; $display("FAIL mid_async_ctl: req=%b addr=%0d end=%b busy=%b want 0", note_req, note_addr, song_end, voice_busy); end
    checks++; if ({freq1, freq2, freq3, freq4} !== '0) begin failures++; $display("FAIL mid_async_freq: got %h %h %h %h want 0", freq1, freq2, freq3, freq4); end
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    n = 0;
    while (!note_req && n < 10) begin @(negedge clk); n++; end
    checks++; if ({note_req, note_addr} !== {1'b1, 4'd0}) begin failures++; $display("FAIL mid_restart: req=%b addr=%0d want 1 0", note_req, note_addr); end
    n = 0;
    while (voice_busy == 4'b0000 && n < 20) begin @(negedge clk); n++; end
    checks++; if ({freq1, voice_busy} !== {12'h3AA, 4'b0001}) begin failures++; $display("FAIL mid_refetch: freq1=%h busy=%b want 3aa 0001", freq1, voice_busy); end
    play = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_wait();
    test_any();
    test_song_end();
    test_skip_rest();
    test_wrap();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
